// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-bus controller: FSM state
// encoding, command-byte layout and default bus widths.
package spi_reg_pkg;

    localparam int ADDR_W_DEFAULT = 7;
    localparam int DATA_W_DEFAULT = 8;

    // Bit of the command byte that selects a read (1) or a write (0).
    localparam int CMD_RD_BIT = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR       = 3'd2,
        RD_FETCH = 3'd3,
        RD_WAIT  = 3'd4,
        RD_SEND  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_ncs_sync.sv
// Two-flop synchronizer for the raw SPI chip select. Both flops reset to 1
// so that the controller sees "deselected" while in reset.
module spi_ncs_sync
    import spi_reg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ncs,
    output logic ncs_sync
);

    logic meta;

    // Double-register the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            ncs_sync <= 1'b1;
        end else begin
            meta     <= ncs;
            ncs_sync <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame-level controller above the SPI byte engine. The first byte of each
// chip-select frame is a command (bit 7 = read, bits 6:0 = address); write
// frames commit the following bytes to the register bus, read frames fetch
// register data and keep the engine's transmit side loaded.
// Build option: define SPI_REG_AUTOINC_EN to advance the address after
// every write and every sent read byte (burst access); otherwise the
// address stays fixed for the whole frame.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ncs,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    output logic              tx_call,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy
);

`ifdef SPI_REG_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    state_t            state, state_n;
    logic              ncs_s;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] addr_adv;
    logic              tx_call_n;
    logic [DATA_W-1:0] tx_data_n;
    logic [DATA_W-1:0] reg_wdata_n;
    logic              reg_we_n;
    logic              reg_re_n;
    // flush marks when the synchronizer output reflects the real pin after
    // reset; armed requires a deselected pin before the first frame so that
    // a reset in the middle of a frame cannot resume that frame.
    logic [1:0]        flush;
    logic              armed;
    logic              armed_n;

    spi_ncs_sync u_ncs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ncs      (ncs),
        .ncs_sync (ncs_s)
    );

    assign addr_adv = AUTOINC ? reg_addr + 1'b1 : reg_addr;
    assign busy     = (state != IDLE);

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        state_n     = state;
        addr_n      = reg_addr;
        tx_call_n   = tx_call;
        tx_data_n   = tx_data;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;
        armed_n     = armed | (flush[1] & ncs_s);

        if (ncs_s) begin
            state_n   = IDLE;
            addr_n    = '0;
            tx_call_n = 1'b0;
            tx_data_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state_n = CMD;
                    end
                end
                CMD: begin
                    if (rx_done) begin
                        addr_n = rx_data[ADDR_W-1:0];
                        if (rx_data[CMD_RD_BIT]) begin
                            reg_re_n = 1'b1;
                            state_n  = RD_FETCH;
                        end else begin
                            state_n  = WR;
                        end
                    end
                end
                WR: begin
                    if (reg_we) begin
                        addr_n = addr_adv;
                    end
                    if (rx_done) begin
                        reg_we_n    = 1'b1;
                        reg_wdata_n = rx_data;
                    end
                end
                RD_FETCH: begin
                    state_n = RD_WAIT;
                end
                RD_WAIT: begin
                    tx_data_n = reg_rdata;
                    tx_call_n = 1'b1;
                    state_n   = RD_SEND;
                end
                RD_SEND: begin
                    if (tx_done) begin
                        addr_n   = addr_adv;
                        reg_re_n = 1'b1;
                        state_n  = RD_FETCH;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reg_addr  <= '0;
            tx_call   <= 1'b0;
            tx_data   <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            flush     <= 2'b00;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            reg_addr  <= addr_n;
            tx_call   <= tx_call_n;
            tx_data   <= tx_data_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
            flush     <= {flush[0], 1'b1};
            armed     <= armed_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl. Drives byte-level engine pulses,
// emulates a register file on the bus and compares against a frame-level
// model. Honours SPI_REG_AUTOINC_EN the same way as the design.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       ncs;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_call;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] regFile [128];
    logic [7:0] refMem  [128];
    logic [7:0] frameData [4];
    logic       pokeEn;
    logic [6:0] pokeAddr;
    logic [7:0] pokeData;
    int         weCount = 0;
    int         reCount = 0;
    int         compareCount = 0;
    int         failCount = 0;

    spi_reg_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ncs       (ncs),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_done   (tx_done),
        .tx_call   (tx_call),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file on the bus: registered read data one cycle after reg_re.
    always @(posedge clk) begin
        if (pokeEn) begin
            regFile[pokeAddr] <= pokeData;
        end else if (reg_we) begin
            regFile[reg_addr] <= reg_wdata;
        end
        if (reg_re) begin
            reg_rdata <= regFile[reg_addr];
        end
    end

    // Count every strobe cycle so stray or stretched strobes show up.
    always @(negedge clk) begin
        if (reg_we) weCount++;
        if (reg_re) reCount++;
    end

    // Hard bound on total run time.
    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Address of the i-th data byte of a frame starting at base.
    function automatic logic [6:0] addrAt(input logic [6:0] base, input int i);
        return AUTO_INC ? 7'((int'(base) + i) % 128) : base;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pokeReg(input logic [6:0] addr, input logic [7:0] data);
        pokeAddr = addr;
        pokeData = data;
        pokeEn   = 1'b1;
        @(negedge clk);
        pokeEn   = 1'b0;
        refMem[addr] = data;
    endtask

    // One byte completes: rx_done (and tx_done when a byte was loaded).
    task automatic sendByte(input logic [7:0] b, input bit withTx);
        rx_data = b;
        rx_done = 1'b1;
        tx_done = withTx;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic applyStimulus(input bit isRead, input logic [6:0] startAddr, input int nData);
        int         weBase;
        int         reBase;
        int         lat;
        bit         txLoaded;
        logic [6:0] a;
        weBase = weCount;
        reBase = reCount;
        a      = startAddr;
        ncs    = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("busy_cmd", 32'(busy), 32'(1));
        repeat ($urandom_range(130, 150)) @(negedge clk);
        sendByte({isRead, startAddr}, 1'b0);
        if (isRead) begin
            checkOutput("rd_fetch0", 32'({reg_re, reg_addr}), 32'({1'b1, startAddr}));
            repeat (2) @(negedge clk);
            checkOutput("rd_data0", 32'({tx_call, tx_data}), 32'({1'b1, refMem[startAddr]}));
        end
        for (int k = 0; k < nData; k++) begin
            repeat (8) @(negedge clk);
            txLoaded = tx_call;
            a = addrAt(startAddr, k);
            if (isRead) begin
                checkOutput("miso", 32'({tx_call, tx_data}), 32'({1'b1, refMem[a]}));
            end else begin
                checkOutput("wr_no_tx", 32'(tx_call), 32'(0));
            end
            repeat ($urandom_range(60, 70)) @(negedge clk);
            if (!isRead) begin
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
            repeat ($urandom_range(60, 70)) @(negedge clk);
            sendByte(frameData[k], txLoaded);
            if (isRead) begin
                a = addrAt(startAddr, k + 1);
                checkOutput("rd_fetch", 32'({reg_re, reg_addr}), 32'({1'b1, a}));
                repeat (2) @(negedge clk);
                checkOutput("rd_data", 32'({tx_call, tx_data}), 32'({1'b1, refMem[a]}));
            end else begin
                checkOutput("wr_strobe", 32'({reg_we, reg_addr, reg_wdata}),
                            32'({1'b1, a, frameData[k]}));
                refMem[a] = frameData[k];
            end
        end
        repeat (10) @(negedge clk);
        ncs = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!busy) begin
                lat = c;
                break;
            end
        end
        checkOutput("busy_fall", 32'(lat >= 2 && lat <= 3), 32'(1));
        checkOutput("idle_clear", 32'({tx_call, tx_data, reg_addr, reg_we, reg_re}), 32'(0));
        checkOutput("we_count", 32'(weCount - weBase), 32'(isRead ? 0 : nData));
        checkOutput("re_count", 32'(reCount - reBase), 32'(isRead ? nData + 1 : 0));
        repeat (4) @(negedge clk);
        if (!isRead) begin
            checkOutput("regfile", 32'(regFile[a]), 32'(refMem[a]));
        end
    endtask

    // Directed test-plan frames, reset/abort cases, then random frames.
    initial begin
        bit isRd;
        int n;
        int weBase;
        int reBase;
        rst_n    = 1'b0;
        ncs      = 1'b1;
        rx_data  = 8'h00;
        rx_done  = 1'b0;
        tx_done  = 1'b0;
        pokeEn   = 1'b0;
        pokeAddr = '0;
        pokeData = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out",
                    32'({tx_call, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy}), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) pokeReg(7'(i), 8'($urandom));
        checkOutput("idle_after_rst", 32'(busy), 32'(0));

        $display("[TB] write frame 0x05 A5 3C");
        frameData[0] = 8'hA5;
        frameData[1] = 8'h3C;
        applyStimulus(1'b0, 7'h05, 2);

        $display("[TB] read frame 0x85");
        pokeReg(7'h05, 8'h11);
        pokeReg(7'h06, 8'h22);
        frameData[0] = 8'hFF;
        frameData[1] = 8'hFF;
        applyStimulus(1'b1, 7'h05, 2);

        $display("[TB] write frame 0x7F 01 02");
        frameData[0] = 8'h01;
        frameData[1] = 8'h02;
        applyStimulus(1'b0, 7'h7F, 2);

        $display("[TB] read frame 0xFF");
        applyStimulus(1'b1, 7'h7F, 2);

        $display("[TB] chip select raised mid-command");
        weBase = weCount;
        reBase = reCount;
        ncs = 1'b0;
        repeat (70) @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'(1));
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_idle", 32'({busy, tx_call, reg_addr}), 32'(0));
        checkOutput("abort_strobes", 32'((weCount - weBase) + (reCount - reBase)), 32'(0));
        frameData[0] = 8'h55;
        applyStimulus(1'b0, 7'h10, 1);

        $display("[TB] reset during read send");
        ncs = 1'b0;
        repeat (146) @(negedge clk);
        sendByte(8'h85, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("rst_pre", 32'({tx_call, busy}), 32'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async",
                    32'({tx_call, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rst_rearm", 32'({busy, tx_call}), 32'(0));
        ncs = 1'b1;
        repeat (6) @(negedge clk);
        frameData[0] = 8'h00;
        frameData[1] = 8'h00;
        applyStimulus(1'b1, 7'h05, 2);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            isRd = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) frameData[i] = 8'($urandom);
            applyStimulus(isRd, 7'($urandom_range(0, 127)), n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
